// File: rtl/register_file.sv
// register_file: 2^ADDR_W x DATA_W register file with two combinational read ports and one synchronous write port
//   clk  : write clock (rising edge)
//   rst  : asynchronous active-low clear of every register
//   A, B : read addresses, ports 1 and 2; F, G : read data
//   C, D, E : write address, write data, write enable (active-high)
//   Define REGFILE_BYPASS_EN to forward D to a read port whose address matches an enabled write.
module register_file #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A,
  input  logic [ADDR_W-1:0] B,
  input  logic [ADDR_W-1:0] C,
  input  logic [DATA_W-1:0] D,
  input  logic              E,
  output logic [DATA_W-1:0] F,
  output logic [DATA_W-1:0] G
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_mem <= '{default: '0};
    else if (E) r_mem[C] <= D;
`ifdef REGFILE_BYPASS_EN
  logic w_wr;
  assign w_wr = rst && E;
  assign F = (w_wr && A == C) ? D : r_mem[A];
  assign G = (w_wr && B == C) ? D : r_mem[B];
`else
  assign F = r_mem[A];
  assign G = r_mem[B];
`endif
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench for register_file
module tb_register_file;
  logic       clk = 0;
  logic       rst;
  logic [1:0] A, B, C;
  logic [3:0] D;
  logic       E;
  logic [3:0] F, G;
  logic [3:0] model [4];
  logic [3:0] exp_q [$];
  int total = 0;
  int bad = 0;

  register_file dut (.clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_rd(input logic [1:0] a);
`ifdef REGFILE_BYPASS_EN
    if (rst === 1'b1 && E === 1'b1 && a == C) return D;
`endif
    return model[a];
  endfunction

  task automatic clr_model();
    for (int i = 0; i < 4; i++) model[i] = '0;
  endtask

  task automatic push_rd();
    exp_q.push_back(exp_rd(A));
    exp_q.push_back(exp_rd(B));
  endtask

  task automatic pop_chk(input string tag);
    logic [3:0] ef, eg;
    #1;
    ef = exp_q.pop_front();
    eg = exp_q.pop_front();
    check({tag, "_F"}, F, ef);
    check({tag, "_G"}, G, eg);
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [1:0] b);
    @(negedge clk);
    A = a;
    B = b;
    push_rd();
    pop_chk(tag);
  endtask

  task automatic wr(input string tag, input logic [1:0] c, input logic [3:0] d);
    @(negedge clk);
    C = c;
    D = d;
    E = 1;
    A = c;
    B = c;
    push_rd();
    pop_chk({tag, "_pre"});
    @(posedge clk);
    if (rst) model[c] = d;
    #1;
    E = 0;
    push_rd();
    pop_chk({tag, "_post"});
  endtask

  initial begin
    rst = 0; E = 0; A = 0; B = 0; C = 0; D = 0;
    clr_model();
    for (int i = 0; i < 4; i++) rd("rst_sweep", 2'(i), 2'(3 - i));
    wr("rst_wr", 2'd1, 4'b1111);
    rd("rst_wr_chk", 2'd1, 2'd1);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 4; i++) rd("sweep_a", 2'(i), 2'd0);
    for (int i = 0; i < 4; i++) rd("sweep_b", 2'd0, 2'(i));
    for (int i = 0; i < 4; i++) wr("seq_wr", 2'(i), 4'b1000 >> i);
    for (int i = 0; i < 4; i++) rd("seq_rd", 2'(i), 2'(i));
    @(negedge clk);
    C = 3; D = 4'b1111; E = 0;
    @(posedge clk);
    rd("wr_dis", 2'd3, 2'd3);
    rd("dual_03", 2'd0, 2'd3);
    rd("dual_11", 2'd1, 2'd1);
    wr("rdw", 2'd2, 4'b1010);
    rd("rdw_other", 2'd0, 2'd2);
    @(negedge clk);
    A = 0; B = 3;
    #2;
    rst = 0;
    clr_model();
    push_rd();
    pop_chk("async_rst");
    for (int i = 0; i < 4; i++) rd("rst_mid_sweep", 2'(i), 2'(i));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
